// File: rtl/dmr_recovery_pkg.sv
// Shared types for the DMR instruction-fetch recovery controller.
// Recovery FSM state encoding and the lifetime mismatch counter helper.
package dmr_recovery_pkg;

   localparam int unsigned MismatchCntW = 16;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_DRAIN,
      ST_RESYNC,
      ST_VERIFY,
      ST_FAULT
   } recovery_state_e;

   function automatic logic [MismatchCntW-1:0] sat_inc(
      input logic [MismatchCntW-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dmr_recovery_timer.sv
// RESYNC watchdog: counts enabled cycles, flags expiry on the last one.
// Only instantiated when DMR_RECOVERY_TIMEOUT_EN is defined.
module dmr_recovery_timer #(
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] Last = CntW'(TimeoutCycles - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && cnt_q != Last) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire = enable & (cnt_q == Last);

endmodule

// File: rtl/dmr_instr_recovery_ctrl.sv
// DMR instruction-fetch recovery FSM: drain, resync, verify, fault.
// Optional RESYNC watchdog enabled by macro DMR_RECOVERY_TIMEOUT_EN.
module dmr_instr_recovery_ctrl
   import dmr_recovery_pkg::*;
#(
   parameter int unsigned NumRetries    = 3,
   parameter int unsigned StableCycles  = 4,
   parameter int unsigned TimeoutCycles = 64
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               mismatch_i,
   input  logic                               req_valid_i,
   input  logic                               req_ready_i,
   output logic                               stall_o,
   output logic                               resync_req_o,
   input  logic                               resync_ack_i,
   input  logic                               clear_i,
   output logic                               fault_o,
   output logic [$clog2(NumRetries+1)-1:0]    retry_cnt_o,
   output logic [MismatchCntW-1:0]            mismatch_cnt_o
);

   localparam int unsigned RetryW = $clog2(NumRetries + 1);
   localparam int unsigned CleanW = $clog2(StableCycles + 1);
   localparam logic [RetryW-1:0] MaxRetry = RetryW'(NumRetries);
   localparam logic [CleanW-1:0] CleanLast = CleanW'(StableCycles - 1);

   if (NumRetries < 1) begin : g_chk_retries
      $error("NumRetries must be at least 1");
   end
   if (StableCycles < 1) begin : g_chk_stable
      $error("StableCycles must be at least 1");
   end
   if (TimeoutCycles < 1) begin : g_chk_timeout
      $error("TimeoutCycles must be at least 1");
   end

   recovery_state_e         state_q;
   logic                    pending_q;
   logic                    resync_q;
   logic [RetryW-1:0]       retry_q;
   logic [CleanW-1:0]       clean_q;
   logic [MismatchCntW-1:0] mismatch_cnt_q;

   logic fetch_busy;
   logic in_resync;
   logic expire;

   assign fetch_busy = req_valid_i & ~req_ready_i;
   assign in_resync  = (state_q == ST_RESYNC);

`ifdef DMR_RECOVERY_TIMEOUT_EN
   dmr_recovery_timer #(
      .TimeoutCycles(TimeoutCycles)
   ) u_timer (
      .clk   (clk_i),
      .rst   (rst_i),
      .enable(in_resync),
      .clear (~in_resync),
      .expire(expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_RUN;
         pending_q      <= 1'b0;
         resync_q       <= 1'b0;
         retry_q        <= '0;
         clean_q        <= '0;
         mismatch_cnt_q <= '0;
      end else begin
         pending_q <= fetch_busy;
         resync_q  <= 1'b0;
         unique case (state_q)
            ST_RUN: begin
               if (mismatch_i) begin
                  state_q        <= ST_DRAIN;
                  retry_q        <= retry_q + 1'b1;
                  mismatch_cnt_q <= sat_inc(mismatch_cnt_q);
               end
            end
            ST_DRAIN: begin
               // Resync only once no fetch is outstanding toward the ICache
               if (!(pending_q || fetch_busy)) begin
                  state_q  <= ST_RESYNC;
                  resync_q <= 1'b1;
               end
            end
            ST_RESYNC: begin
               if (resync_ack_i) begin
                  state_q <= ST_VERIFY;
                  clean_q <= '0;
               end else if (expire) begin
                  state_q <= ST_FAULT;
               end
            end
            ST_VERIFY: begin
               if (mismatch_i) begin
                  mismatch_cnt_q <= sat_inc(mismatch_cnt_q);
                  if (retry_q < MaxRetry) begin
                     state_q <= ST_DRAIN;
                     retry_q <= retry_q + 1'b1;
                  end else begin
                     state_q <= ST_FAULT;
                  end
               end else if (clean_q == CleanLast) begin
                  state_q <= ST_RUN;
                  retry_q <= '0;
               end else begin
                  clean_q <= clean_q + 1'b1;
               end
            end
            ST_FAULT: begin
               if (clear_i) begin
                  state_q <= ST_RUN;
                  retry_q <= '0;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign stall_o        = (state_q == ST_DRAIN) || in_resync ||
                           (state_q == ST_FAULT);
   assign fault_o        = (state_q == ST_FAULT);
   assign resync_req_o   = resync_q;
   assign retry_cnt_o    = retry_q;
   assign mismatch_cnt_o = mismatch_cnt_q;

endmodule

// File: tb/tb_dmr_instr_recovery_ctrl.sv
// Directed bench for dmr_instr_recovery_ctrl (vector table plus sequences).
// Watchdog cases are built only with DMR_RECOVERY_TIMEOUT_EN defined.
module tb_dmr_instr_recovery_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mismatch = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready = 1'b0;
   logic        resync_ack = 1'b0;
   logic        clear = 1'b0;
   logic        stall;
   logic        resync_req;
   logic        fault;
   logic [1:0]  retry_cnt;
   logic [15:0] mismatch_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmr_instr_recovery_ctrl #(
      .NumRetries   (3),
      .StableCycles (4),
      .TimeoutCycles(8)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mismatch_i    (mismatch),
      .req_valid_i   (req_valid),
      .req_ready_i   (req_ready),
      .stall_o       (stall),
      .resync_req_o  (resync_req),
      .resync_ack_i  (resync_ack),
      .clear_i       (clear),
      .fault_o       (fault),
      .retry_cnt_o   (retry_cnt),
      .mismatch_cnt_o(mismatch_cnt)
   );

   typedef logic [20:0] obs_t;

   typedef struct packed {
      logic [5:0] in;
      obs_t       exp;
   } vec_t;

   vec_t vecs[$];

   function automatic obs_t pk(input logic [2:0] srf, input int rc, input int mc);
      return {srf, 2'(rc), 16'(mc)};
   endfunction

   function automatic vec_t v(input logic [5:0] in, input logic [2:0] srf,
                              input int rc, input int mc);
      vec_t r;
      r.in  = in;
      r.exp = pk(srf, rc, mc);
      return r;
   endfunction

   task automatic drive(input logic [5:0] in);
      {rst, mismatch, req_valid, req_ready, resync_ack, clear} = in;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input obs_t exp);
      obs_t act;
      act = {stall, resync_req, fault, retry_cnt, mismatch_cnt};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got stall=%0b req=%0b fault=%0b retry=%0d cnt=%0d, want stall=%0b req=%0b fault=%0b retry=%0d cnt=%0d",
                  name, act[20], act[19], act[18], act[17:16], act[15:0],
                  exp[20], exp[19], exp[18], exp[17:16], exp[15:0]);
      end
   endtask

   initial begin
      // inputs: {rst, mismatch, valid, ready, ack, clear}
      // outputs: {stall, resync_req, fault}, retry, mismatch count
      vecs.push_back(v(6'b000000, 3'b000, 0, 0));
      vecs.push_back(v(6'b010000, 3'b100, 1, 1));
      vecs.push_back(v(6'b000000, 3'b110, 1, 1));
      vecs.push_back(v(6'b010000, 3'b100, 1, 1));
      vecs.push_back(v(6'b000000, 3'b100, 1, 1));
      vecs.push_back(v(6'b000010, 3'b000, 1, 1));
      vecs.push_back(v(6'b000010, 3'b000, 1, 1));
      vecs.push_back(v(6'b000000, 3'b000, 1, 1));
      vecs.push_back(v(6'b000000, 3'b000, 1, 1));
      vecs.push_back(v(6'b000000, 3'b000, 0, 1));
      vecs.push_back(v(6'b000011, 3'b000, 0, 1));
      // fetch in flight: ready low for 5 cycles inside DRAIN
      vecs.push_back(v(6'b011000, 3'b100, 1, 2));
      for (int i = 0; i < 5; i++)
         vecs.push_back(v(6'b001000, 3'b100, 1, 2));
      vecs.push_back(v(6'b001100, 3'b100, 1, 2));
      vecs.push_back(v(6'b000000, 3'b110, 1, 2));
      vecs.push_back(v(6'b000000, 3'b100, 1, 2));
      vecs.push_back(v(6'b000010, 3'b000, 1, 2));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v(6'b000000, 3'b000, 1, 2));
      vecs.push_back(v(6'b000000, 3'b000, 0, 2));
      // retries exhausted into FAULT, then clear
      vecs.push_back(v(6'b100000, 3'b000, 0, 0));
      vecs.push_back(v(6'b010000, 3'b100, 1, 1));
      vecs.push_back(v(6'b000000, 3'b110, 1, 1));
      vecs.push_back(v(6'b000010, 3'b000, 1, 1));
      vecs.push_back(v(6'b010000, 3'b100, 2, 2));
      vecs.push_back(v(6'b000000, 3'b110, 2, 2));
      vecs.push_back(v(6'b000010, 3'b000, 2, 2));
      vecs.push_back(v(6'b010000, 3'b100, 3, 3));
      vecs.push_back(v(6'b000000, 3'b110, 3, 3));
      vecs.push_back(v(6'b000010, 3'b000, 3, 3));
      vecs.push_back(v(6'b010000, 3'b101, 3, 4));
      vecs.push_back(v(6'b010010, 3'b101, 3, 4));
      vecs.push_back(v(6'b000000, 3'b101, 3, 4));
      vecs.push_back(v(6'b010001, 3'b000, 0, 4));
      vecs.push_back(v(6'b010000, 3'b100, 1, 5));
      vecs.push_back(v(6'b000000, 3'b110, 1, 5));
      vecs.push_back(v(6'b100000, 3'b000, 0, 0));
      vecs.push_back(v(6'b000000, 3'b000, 0, 0));
      vecs.push_back(v(6'b000000, 3'b000, 0, 0));

      drive(6'b100000);
      repeat (2) step();
      check("reset", pk(3'b000, 0, 0));
      drive(6'b000000);

      foreach (vecs[i]) begin
         drive(vecs[i].in);
         step();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // asynchronous reset while in RESYNC
      drive(6'b010000);
      step();
      drive(6'b000000);
      step();
      check("pre_async_rst", pk(3'b110, 1, 1));
      #2 rst = 1'b1;
      #1 check("async_rst", pk(3'b000, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst%0d", i), pk(3'b000, 0, 0));
      end

      // held mismatch/ack/clear: 11-cycle loop adds 4 events per lap
      mismatch = 1'b1;
      resync_ack = 1'b1;
      clear = 1'b1;
      repeat (1100) step();
      check("loop_run", pk(3'b000, 0, 400));
      repeat (10) step();
      check("loop_fault", pk(3'b101, 3, 404));
      step();
      check("loop_clear", pk(3'b000, 0, 404));
      drive(6'b000000);
      step();

      // saturation from a preloaded near-full counter
      @(negedge clk);
      force dut.mismatch_cnt_q = 16'hFFFD;
      #1 release dut.mismatch_cnt_q;
      drive(6'b010000);
      step();
      check("sat_inc1", pk(3'b100, 1, 16'hFFFE));
      drive(6'b000000);
      step();
      drive(6'b000010);
      step();
      drive(6'b010000);
      step();
      check("sat_inc2", pk(3'b100, 2, 16'hFFFF));
      drive(6'b000000);
      step();
      drive(6'b000010);
      step();
      drive(6'b010000);
      step();
      check("sat_hold", pk(3'b100, 3, 16'hFFFF));

`ifdef DMR_RECOVERY_TIMEOUT_EN
      drive(6'b100000);
      step();
      drive(6'b010000);
      step();
      drive(6'b000000);
      step();
      for (int i = 1; i < 8; i++) begin
         step();
         check($sformatf("wd_wait%0d", i), pk(3'b100, 1, 1));
      end
      step();
      check("wd_expire", pk(3'b101, 1, 1));
      drive(6'b000001);
      step();
      drive(6'b010000);
      step();
      drive(6'b000000);
      step();
      repeat (7) step();
      check("wd_wait_ack", pk(3'b100, 1, 2));
      drive(6'b000010);
      step();
      check("wd_ack_wins", pk(3'b000, 1, 2));
      drive(6'b000000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
